// File: rtl/rv_hazard_ctrl.sv
// Pipeline hazard controller: per-stage valid tracking, stalls, branch flushes, EX operand forwarding.
// Optional feature macro: RV_HAZARD_FORWARDING_EN (forwarding plus single-cycle load-use stall).
module rv_hazard_ctrl #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_wr_en,
  input  logic                  id_is_load,
  input  logic                  ex_branch_taken,
  input  logic [XLEN-1:0]       ex_rs1_data,
  input  logic [XLEN-1:0]       ex_rs2_data,
  input  logic [XLEN-1:0]       m_fwd_data,
  input  logic [XLEN-1:0]       w_fwd_data,
  output logic [XLEN-1:0]       ex_op_a,
  output logic [XLEN-1:0]       ex_op_b,
  output logic                  pc_wr_en,
  output logic                  pc_sel_target,
  output logic                  if_id_wr_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  valid_d,
  output logic                  valid_e,
  output logic                  valid_m,
  output logic                  valid_w,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      retire_cnt
);

  logic [REG_ADDR_W-1:0] e_rd, m_rd, w_rd, e_rs1, e_rs2;
  logic e_wr_en, m_wr_en, w_wr_en, e_is_load, m_is_load, e_uses_rs1, e_uses_rs2;
  logic e_hit, m_hit, w_hit, stall_raw, flush, stall;

  function automatic logic writer_hit(input logic v, input logic we,
                                      input logic [REG_ADDR_W-1:0] rd,
                                      input logic [REG_ADDR_W-1:0] rs, input logic uses);
    return v & we & (rd != '0) & (rd == rs) & uses;
  endfunction

  assign e_hit = writer_hit(valid_e, e_wr_en, e_rd, id_rs1, id_uses_rs1) |
                 writer_hit(valid_e, e_wr_en, e_rd, id_rs2, id_uses_rs2);
  assign m_hit = writer_hit(valid_m, m_wr_en, m_rd, id_rs1, id_uses_rs1) |
                 writer_hit(valid_m, m_wr_en, m_rd, id_rs2, id_uses_rs2);
  assign w_hit = writer_hit(valid_w, w_wr_en, w_rd, id_rs1, id_uses_rs1) |
                 writer_hit(valid_w, w_wr_en, w_rd, id_rs2, id_uses_rs2);

`ifdef RV_HAZARD_FORWARDING_EN
  logic fa_m, fa_w, fb_m, fb_w;

  assign stall_raw = valid_d & e_hit & e_is_load;

  // A load in M has no data yet on ALU_M, so only non-load M writers forward.
  assign fa_m = writer_hit(valid_m, m_wr_en, m_rd, e_rs1, e_uses_rs1) & ~m_is_load;
  assign fb_m = writer_hit(valid_m, m_wr_en, m_rd, e_rs2, e_uses_rs2) & ~m_is_load;
  assign fa_w = writer_hit(valid_w, w_wr_en, w_rd, e_rs1, e_uses_rs1);
  assign fb_w = writer_hit(valid_w, w_wr_en, w_rd, e_rs2, e_uses_rs2);

  always_comb begin
    ex_op_a = ex_rs1_data;
    ex_op_b = ex_rs2_data;
    if (!rst) begin
      if (fa_m)      ex_op_a = m_fwd_data;
      else if (fa_w) ex_op_a = w_fwd_data;
      if (fb_m)      ex_op_b = m_fwd_data;
      else if (fb_w) ex_op_b = w_fwd_data;
    end
  end
`else
  logic unused_nofwd;

  assign stall_raw    = valid_d & (e_hit | m_hit | w_hit);
  assign ex_op_a      = ex_rs1_data;
  assign ex_op_b      = ex_rs2_data;
  assign unused_nofwd = ^{e_is_load, m_is_load, e_rs1, e_rs2, e_uses_rs1, e_uses_rs2,
                          m_fwd_data, w_fwd_data};
`endif

  assign flush = valid_e & ex_branch_taken;
  assign stall = stall_raw & ~flush;

  always_comb begin
    pc_wr_en      = 1'b1;
    pc_sel_target = 1'b0;
    if_id_wr_en   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    if (rst) begin
      pc_wr_en    = 1'b0;
      if_id_wr_en = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (flush) begin
      pc_sel_target = 1'b1;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (stall) begin
      pc_wr_en    = 1'b0;
      if_id_wr_en = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d    <= 1'b0;
      valid_e    <= 1'b0;
      valid_m    <= 1'b0;
      valid_w    <= 1'b0;
      e_rd       <= '0;
      m_rd       <= '0;
      w_rd       <= '0;
      e_rs1      <= '0;
      e_rs2      <= '0;
      e_uses_rs1 <= 1'b0;
      e_uses_rs2 <= 1'b0;
      e_wr_en    <= 1'b0;
      m_wr_en    <= 1'b0;
      w_wr_en    <= 1'b0;
      e_is_load  <= 1'b0;
      m_is_load  <= 1'b0;
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (stall)   stall_cnt  <= stall_cnt + CNT_W'(1);
      if (flush)   flush_cnt  <= flush_cnt + CNT_W'(1);
      if (valid_w) retire_cnt <= retire_cnt + CNT_W'(1);

      if (flush)       valid_d <= 1'b0;
      else if (!stall) valid_d <= 1'b1;

      // Bubble into E on stall or flush; otherwise capture the decode-stage instruction.
      if (flush || stall) begin
        valid_e    <= 1'b0;
        e_wr_en    <= 1'b0;
        e_is_load  <= 1'b0;
        e_uses_rs1 <= 1'b0;
        e_uses_rs2 <= 1'b0;
      end else begin
        valid_e    <= valid_d;
        e_rd       <= id_rd;
        e_wr_en    <= id_rd_wr_en;
        e_is_load  <= id_is_load;
        e_rs1      <= id_rs1;
        e_rs2      <= id_rs2;
        e_uses_rs1 <= id_uses_rs1;
        e_uses_rs2 <= id_uses_rs2;
      end

      valid_m   <= valid_e;
      m_rd      <= e_rd;
      m_wr_en   <= e_wr_en;
      m_is_load <= e_is_load;
      valid_w   <= valid_m;
      w_rd      <= m_rd;
      w_wr_en   <= m_wr_en;
    end
  end

endmodule

// File: doc/rv_hazard_ctrl.md
# rv_hazard_ctrl

Parametrised pipeline control block for the 5-stage RISC-V core: it replaces the hard-wired "always advance" pipeline enable with per-stage valid tracking, load-use stalls, taken-branch flushes and EX-stage operand forwarding. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers, drives their write-enable and flush inputs, and muxes the ALU operands. It shadows destination-register info for E/M/W internally and keeps cycle/stall/flush/retire performance counters.

## Interface
- XLEN, 32, datapath width
- REG_ADDR_W, 5, register-address width
- CNT_W, 32, performance-counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the decode-stage instruction
- id_uses_rs1, id_uses_rs2  in  1  source actually read (from microcode)
- id_rd  in  REG_ADDR_W  destination of decode-stage instruction
- id_rd_wr_en  in  1  decode-stage instruction writes rd
- id_is_load  in  1  decode-stage instruction's writeback source is data memory
- ex_branch_taken  in  1  branch_en_E AND zero_flag
- ex_rs1_data, ex_rs2_data  in  XLEN  register-file values from ID/EX
- m_fwd_data  in  XLEN  ALU_M
- w_fwd_data  in  XLEN  RD_DATA (writeback bus)
- ex_op_a, ex_op_b  out  XLEN  forwarded operands (op_b before the immediate mux)
- pc_wr_en  out  1  PC advances
- pc_sel_target  out  1  PC loads PC_target
- if_id_wr_en  out  1  IF/ID register enable
- if_id_flush, id_ex_flush  out  1  load bubble into that register next edge
- valid_d, valid_e, valid_m, valid_w  out  1  stage holds a real instruction
- cycle_cnt, stall_cnt, flush_cnt, retire_cnt  out  CNT_W  performance counters

## Operation
- Shadow registers per stage E/M/W: rd, wr_en, is_load, valid; advance E→M→W every cycle; E loaded from ID inputs unless bubble/flush (then valid_e=0, wr_en=0).
- Writer match at stage X: valid_X & wr_en_X & rd_X≠0 & rd_X==id_rsN & id_usesN.
- Stall (FORWARDING_EN): valid_d & E-match & is_load_E. Stall: pc_wr_en=0, if_id_wr_en=0, id_ex_flush=1.
- Flush: valid_e & ex_branch_taken → pc_sel_target=1, pc_wr_en=1, if_id_flush=1, id_ex_flush=1. Flush overrides stall in the same cycle.
- Idle: pc_wr_en=1, if_id_wr_en=1, flushes 0.
- valid_d: set on IF/ID advance unless flushed; held on stall.
- Forwarding: for each operand, M-match (non-load) → m_fwd_data; else W-match → w_fwd_data; else register-file value. M beats W. rd=0 never forwarded. Matching uses the E instruction's sources, registered from id_rs*/id_uses* when E loads.
- Counters: cycle_cnt +1 each non-reset cycle; stall_cnt +1 per stall cycle (not counted when flush wins); flush_cnt +1 per taken-branch event; retire_cnt +1 when valid_w. All wrap 2^CNT_W−1 → 0.

## Timing
- Hazard/control outputs and forwarding muxes combinational from inputs and registered state; same-cycle response.
- Reset (rst high at edge): all valids 0, shadow wr_en 0, counters 0. While rst high: pc_wr_en=0, pc_sel_target=0, if_id_wr_en=0, if_id_flush=1, id_ex_flush=1, ex_op_a/b pass register-file values.
- First cycle after reset release: pc_wr_en=1; valid_d=1 after first edge.
- Load-use stall exactly 1 cycle; next cycle forwards from W.
- Branch penalty exactly 2 bubbles (D and E instructions squashed).
- Reset mid-stall or mid-flush: state cleared at that edge, no counter increment.

## Configuration
- RV_HAZARD_FORWARDING_EN defined: forwarding and 1-cycle load-use stall as above.
- Undefined: ex_op_a/b = register-file values; stall whenever any E, M or W writer matches a used source (any type); stall persists until no match; counters and flush unchanged.

## Test plan
- Reset: hold rst 3 cycles → all valids 0, counters 0, pc_wr_en=0; release → cycle_cnt=1 after one edge.
- ADD x5 in M, ADD x5 in W, E reads x5: m_fwd_data=0x11, w_fwd_data=0x22 → ex_op_a=0x11.
- LW x6 in E, ID reads x6 → one stall cycle, stall_cnt=1, next cycle ex_op_b=w_fwd_data.
- ex_branch_taken with load-use stall in same cycle → pc_sel_target=1, no stall, flush_cnt=1, stall_cnt unchanged, valid_e=0 next cycle.
- rd=x0 writer in M, E reads x0 → ex_op_a=ex_rs1_data (0).
- Forwarding undefined: ADDI x7 then ADD reading x7 → 3 stall cycles, then proceeds; CNT_W=4 counter wraps 15→0.
